bootrom_fetch: RTL and testbench

BOOTROM_FETCH -- requirements
Module: bootrom_fetch

---
 rtl/bootrom_pkg.sv | 36 +++
 rtl/bootrom_skid.sv | 75 +++++++
 rtl/bootrom_fetch.sv | 179 +++++++++++++++++
 tb/tb_bootrom_fetch.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bootrom_pkg.sv
// Shared types and constants for the boot ROM fetch unit.
//   fetch_state_e : FSM states of the fetch controller
//   beat_t        : one response beat as held in the response buffer
//   beat_addr()   : byte address of burst beat idx (wrapped or line-aligned)
package bootrom_pkg;

    localparam int unsigned ROM_BYTES           = 1024;
    localparam int unsigned DEFAULT_BURST_BEATS = 4;
    localparam int unsigned ADDR_W              = 32;
    localparam int unsigned DATA_W              = 32;
    localparam int unsigned IDX_W               = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        ERR   = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic              err;
        logic              last;
        logic [DATA_W-1:0] data;
    } beat_t;

    // Beat idx of a line fill: wrap=1 starts at the requested word and wraps
    // inside the 16-byte line, wrap=0 walks the line from word 0.
    function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [IDX_W-1:0]  idx,
                                                    input logic              wrap);
        logic [IDX_W-1:0] w;
        w = wrap ? IDX_W'(a[3:2] + idx) : idx;
        return {a[ADDR_W-1:4], w, 2'b00};
    endfunction

endpackage

// File: rtl/bootrom_skid.sv
// Two-entry response buffer. The head entry is a register that drives the
// response outputs directly, so a stalled beat never changes.
//   clk, rst     : clock, synchronous active-high reset
//   push_i       : write push_beat_i this cycle
//   push_beat_i  : beat to store
//   pop_i        : consumer takes the head beat this cycle
//   head_o       : oldest beat (zero when empty)
//   count_o      : number of stored beats (0..2)
//   full_o       : both entries occupied
//   empty_o      : no beat stored
module bootrom_skid
    import bootrom_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  beat_t      push_beat_i,
    input  logic       pop_i,
    output beat_t      head_o,
    output logic [1:0] count_o,
    output logic       full_o,
    output logic       empty_o
);

    beat_t head_q;
    beat_t tail_q;
    logic  head_vld_q;
    logic  tail_vld_q;
    logic  pop_ok;

    assign pop_ok = pop_i & head_vld_q;

    // Tail is only ever valid behind a valid head.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
        end else begin
            case ({push_i, pop_ok})
                2'b10: begin
                    if (!head_vld_q) begin
                        head_q     <= push_beat_i;
                        head_vld_q <= 1'b1;
                    end else begin
                        tail_q     <= push_beat_i;
                        tail_vld_q <= 1'b1;
                    end
                end
                2'b01: begin
                    head_q     <= tail_vld_q ? tail_q : '0;
                    head_vld_q <= tail_vld_q;
                    tail_vld_q <= 1'b0;
                end
                2'b11: begin
                    if (tail_vld_q) begin
                        head_q <= tail_q;
                        tail_q <= push_beat_i;
                    end else begin
                        head_q <= push_beat_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign head_o  = head_q;
    assign count_o = {head_vld_q & tail_vld_q, head_vld_q ^ tail_vld_q};
    assign full_o  = tail_vld_q;
    assign empty_o = ~head_vld_q;

endmodule

// File: rtl/bootrom_fetch.sv
// Boot ROM fetch unit: turns CPU single-word and line-fill read requests into
// ROM accesses and streams the data back as response beats. Writes and
// addresses outside the 1 KiB window get a single error beat.
// Build option: define BOOTROM_WRAP_EN for critical-word-first wrapped bursts;
// otherwise bursts walk the line in ascending order from word 0.
//   clk, rst                      : clock, synchronous active-high reset
//   req_valid/req_ready           : request handshake (ready only when idle)
//   req_addr, req_burst, req_write: byte address, line-fill select, write flag
//   rsp_valid/rsp_ready           : response beat handshake
//   rsp_data, rsp_last, rsp_err   : beat payload
//   rom_addr, rom_q               : ROM address out, data back one cycle later
module bootrom_fetch
    import bootrom_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FC00,
    parameter int unsigned BURST_BEATS = DEFAULT_BURST_BEATS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_burst,
    input  logic        req_write,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_last,
    output logic        rsp_err,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_q
);

`ifdef BOOTROM_WRAP_EN
    localparam logic WRAP_EN = 1'b1;
`else
    localparam logic WRAP_EN = 1'b0;
`endif

    localparam int unsigned     WIN_W          = ADDR_W + 1;
    localparam logic [IDX_W-1:0] LAST_BURST_IDX = IDX_W'(BURST_BEATS - 1);
    localparam logic [WIN_W-1:0] WIN_LO         = {1'b0, BASE_ADDR};
    localparam logic [WIN_W-1:0] WIN_HI         = WIN_LO + WIN_W'(ROM_BYTES - 1);

    fetch_state_e      state_q;
    logic              req_ready_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [IDX_W-1:0]  beat_idx_q;
    logic [IDX_W-1:0]  last_idx_q;
    logic              inflight_q;
    logic              inflight_last_q;

    logic [IDX_W-1:0]  next_idx_d;
    logic [IDX_W-1:0]  first_last_idx_c;
    logic [ADDR_W-1:0] aligned_c;
    logic [ADDR_W-1:0] line_c;
    logic [ADDR_W-1:0] lo_c;
    logic [ADDR_W-1:0] hi_c;
    logic              in_win_c;
    logic              hs_c;
    logic              bad_c;
    logic              pop_c;
    logic [2:0]        occ_c;
    logic              can_issue_c;
    logic              push_c;
    beat_t             push_beat_c;

    beat_t             skid_head;
    logic [1:0]        skid_count;
    logic              skid_full;
    logic              skid_empty;

    // Request decode, window check and buffer occupancy.
    always_comb begin
        aligned_c = req_addr & ~ADDR_W'(3);
        line_c    = req_addr & ~ADDR_W'(15);
        // A burst may touch any word of its line, so the whole line must fit.
        lo_c      = req_burst ? line_c : aligned_c;
        hi_c      = req_burst ? (line_c | ADDR_W'(12)) : aligned_c;
        in_win_c  = ({1'b0, lo_c} >= WIN_LO) && ({1'b0, hi_c} <= WIN_HI);
        hs_c      = req_valid & req_ready_q;
        bad_c     = req_write | ~in_win_c;
        first_last_idx_c = req_burst ? LAST_BURST_IDX : '0;
        next_idx_d = IDX_W'(beat_idx_q + 1'b1);

        pop_c = rsp_valid & rsp_ready;
        // Space must exist for the new beat once everything in flight lands.
        occ_c       = 3'(skid_count) + 3'(inflight_q) - 3'(pop_c);
        can_issue_c = occ_c < 3'd2;

        push_beat_c = '0;
        if (inflight_q) begin
            push_beat_c.last = inflight_last_q;
            push_beat_c.data = rom_q;
        end else begin
            push_beat_c.err  = 1'b1;
            push_beat_c.last = 1'b1;
        end
        push_c = (inflight_q | (hs_c & bad_c)) & (~skid_full | pop_c);
    end

    // Fetch controller; the first ROM address goes out on the accept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            req_ready_q     <= 1'b0;
            rom_addr_q      <= '0;
            req_addr_q      <= '0;
            beat_idx_q      <= '0;
            last_idx_q      <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (hs_c) begin
                        req_ready_q <= 1'b0;
                        if (bad_c) begin
                            state_q <= ERR;
                        end else begin
                            state_q         <= ISSUE;
                            req_addr_q      <= aligned_c;
                            beat_idx_q      <= '0;
                            last_idx_q      <= first_last_idx_c;
                            rom_addr_q      <= req_burst ? beat_addr(aligned_c, '0, WRAP_EN)
                                                         : aligned_c;
                            inflight_q      <= 1'b1;
                            inflight_last_q <= (first_last_idx_c == '0);
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (beat_idx_q == last_idx_q) begin
                        state_q <= DRAIN;
                    end else if (can_issue_c) begin
                        rom_addr_q      <= beat_addr(req_addr_q, next_idx_d, WRAP_EN);
                        beat_idx_q      <= next_idx_d;
                        inflight_q      <= 1'b1;
                        inflight_last_q <= (next_idx_d == last_idx_q);
                    end
                end
                DRAIN, ERR: begin
                    if (pop_c && rsp_last) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    bootrom_skid u_skid (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_c),
        .push_beat_i (push_beat_c),
        .pop_i       (pop_c),
        .head_o      (skid_head),
        .count_o     (skid_count),
        .full_o      (skid_full),
        .empty_o     (skid_empty)
    );

    assign req_ready = req_ready_q;
    assign rom_addr  = rom_addr_q;
    assign rsp_valid = ~skid_empty;
    assign rsp_data  = skid_head.data;
    assign rsp_last  = skid_head.last;
    assign rsp_err   = skid_head.err;

endmodule

// File: tb/tb_bootrom_fetch.sv
// Directed bench for bootrom_fetch. The ROM model returns 0xC0DE_0000 plus the
// word index, combinationally from rom_addr. Expected burst orders follow
// BOOTROM_WRAP_EN.
module tb_bootrom_fetch;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_burst;
    logic        req_write;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        rsp_err;
    logic [31:0] rom_addr;
    logic [31:0] rom_q;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] bd [8];
    logic        bl [8];
    logic        be [8];
    int          bcyc [8];
    int          nb;

    logic [31:0] exp_b [4];
    logic [31:0] exp_first_addr;
    logic [31:0] exp_beat1_addr;
    logic [31:0] exp_last_addr;

    bootrom_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_burst (req_burst),
        .req_write (req_write),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .rsp_err   (rsp_err),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q)
    );

    assign rom_q = 32'hC0DE_0000 | {24'h0, rom_addr[9:2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic b, input logic w);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        chk("req_ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = a;
        req_burst = b;
        req_write = w;
        step();
        req_valid = 1'b0;
        req_burst = 1'b0;
        req_write = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!rsp_valid && n < 8) begin
            step();
            n++;
        end
        chk({tag, "_wait"}, 32'(rsp_valid), 32'd1);
    endtask

    // Record every accepted beat until the last one, bounded.
    task automatic collect();
        int  cyc;
        bit  done;
        cyc  = 0;
        done = 1'b0;
        nb   = 0;
        for (int i = 0; i < 8; i++) begin
            bd[i] = '0; bl[i] = 1'b0; be[i] = 1'b0; bcyc[i] = 0;
        end
        while (!done && cyc < 40) begin
            if (rsp_valid && rsp_ready) begin
                if (nb < 8) begin
                    bd[nb]   = rsp_data;
                    bl[nb]   = rsp_last;
                    be[nb]   = rsp_err;
                    bcyc[nb] = cyc;
                end
                nb++;
                if (rsp_last) done = 1'b1;
            end
            step();
            cyc++;
        end
        chk("collect_done", 32'(done), 32'd1);
    endtask

    task automatic check_one(input string tag, input logic [31:0] d, input logic e);
        chk({tag, "_n"},    32'(nb),    32'd1);
        chk({tag, "_data"}, bd[0],      d);
        chk({tag, "_last"}, 32'(bl[0]), 32'd1);
        chk({tag, "_err"},  32'(be[0]), 32'(e));
    endtask

    task automatic check_burst(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input logic [31:0] w3);
        chk({tag, "_n"},  32'(nb), 32'd4);
        chk({tag, "_d0"}, bd[0], w0);
        chk({tag, "_d1"}, bd[1], w1);
        chk({tag, "_d2"}, bd[2], w2);
        chk({tag, "_d3"}, bd[3], w3);
        chk({tag, "_last"}, {28'h0, bl[3], bl[2], bl[1], bl[0]}, 32'h8);
        chk({tag, "_err"},  {28'h0, be[3], be[2], be[1], be[0]}, 32'h0);
        chk({tag, "_gap"},  32'(bcyc[3] - bcyc[0]), 32'd3);
    endtask

    initial begin
        int vcnt;
`ifdef BOOTROM_WRAP_EN
        exp_b[0] = 32'hC0DE_0005; exp_b[1] = 32'hC0DE_0006;
        exp_b[2] = 32'hC0DE_0007; exp_b[3] = 32'hC0DE_0004;
        exp_first_addr = 32'hFFFF_FC14;
        exp_beat1_addr = 32'hFFFF_FC18;
        exp_last_addr  = 32'hFFFF_FC10;
`else
        exp_b[0] = 32'hC0DE_0004; exp_b[1] = 32'hC0DE_0005;
        exp_b[2] = 32'hC0DE_0006; exp_b[3] = 32'hC0DE_0007;
        exp_first_addr = 32'hFFFF_FC10;
        exp_beat1_addr = 32'hFFFF_FC14;
        exp_last_addr  = 32'hFFFF_FC1C;
`endif
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_burst = 1'b0;
        req_write = 1'b0; rsp_ready = 1'b1;

        // Reset state
        step(); step();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rom_addr",  rom_addr,       32'd0);
        chk("rst_rsp_data",  rsp_data,       32'd0);
        chk("rst_rsp_last",  32'(rsp_last),  32'd0);
        chk("rst_rsp_err",   32'(rsp_err),   32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        // Single read, latency 2
        send(32'hFFFF_FC08, 1'b0, 1'b0);
        chk("single_rom_addr", rom_addr, 32'hFFFF_FC08);
        chk("single_busy", 32'(req_ready), 32'd0);
        collect();
        check_one("single", 32'hC0DE_0002, 1'b0);
        chk("single_latency", 32'(bcyc[0]), 32'd1);
        chk("single_ready_back", 32'(req_ready), 32'd1);

        // Burst, full throughput
        send(32'hFFFF_FC14, 1'b1, 1'b0);
        chk("burst_rom_addr0", rom_addr, exp_first_addr);
        collect();
        check_burst("burst", exp_b[0], exp_b[1], exp_b[2], exp_b[3]);
        chk("burst_latency", 32'(bcyc[0]), 32'd1);

        // Burst with consumer stalled for 5 cycles on beat 1
        rsp_ready = 1'b0;
        send(32'hFFFF_FC14, 1'b1, 1'b0);
        wait_valid("stall");
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_data",  rsp_data,       exp_b[0]);
            chk("stall_last",  32'(rsp_last),  32'd0);
            step();
        end
        chk("stall_rom_addr", rom_addr, exp_beat1_addr);
        rsp_ready = 1'b1;
        collect();
        check_burst("stall", exp_b[0], exp_b[1], exp_b[2], exp_b[3]);

        // Error responses: write, out of window, just below the window
        send(32'hFFFF_FC00, 1'b0, 1'b1);
        collect();
        check_one("err_write", 32'h0, 1'b1);
        chk("err_write_rom_addr", rom_addr, exp_last_addr);
        send(32'h0000_1000, 1'b0, 1'b0);
        collect();
        check_one("err_range", 32'h0, 1'b1);
        chk("err_range_rom_addr", rom_addr, exp_last_addr);
        send(32'hFFFF_FBFC, 1'b0, 1'b0);
        collect();
        check_one("err_below", 32'h0, 1'b1);

        // Top word and top line of the window
        send(32'hFFFF_FFFC, 1'b0, 1'b0);
        collect();
        check_one("top_word", 32'hC0DE_00FF, 1'b0);
        send(32'hFFFF_FFF0, 1'b1, 1'b0);
        collect();
        check_burst("top_line", 32'hC0DE_00FC, 32'hC0DE_00FD, 32'hC0DE_00FE, 32'hC0DE_00FF);

        // Reset during beat 2 of a burst
        send(32'hFFFF_FC00, 1'b1, 1'b0);
        wait_valid("abort");
        step();
        chk("abort_beat2_valid", 32'(rsp_valid), 32'd1);
        chk("abort_beat2_data",  rsp_data,       32'hC0DE_0001);
        rst = 1'b1;
        step();
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd0);
        chk("abort_rom_addr",  rom_addr,       32'd0);
        rst = 1'b0;
        step();
        chk("abort_ready_back", 32'(req_ready), 32'd1);
        vcnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid) vcnt++;
            step();
        end
        chk("abort_no_beats", 32'(vcnt), 32'd0);
        send(32'hFFFF_FC0C, 1'b0, 1'b0);
        collect();
        check_one("after_abort", 32'hC0DE_0003, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
